// File: rtl/fmdll_pkg.sv
// Shared types and constants for the FMDLL select sequencer.
//   state_e    : sequencer states
//   SEL_*      : delay-line input mux select encodings
//   sel_of()   : select value presented while in a given state
package fmdll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        INJECT,
        EXIT
    } state_e;

    localparam logic [1:0] SEL_RECIRC = 2'b00;
    localparam logic [1:0] SEL_INJECT = 2'b10;
    localparam logic [1:0] SEL_EXIT   = 2'b01;

    function automatic logic [1:0] sel_of(input state_e s);
        logic [1:0] sel;
        sel = SEL_RECIRC;
        unique case (s)
            IDLE:   sel = SEL_RECIRC;
            RUN:    sel = SEL_RECIRC;
            INJECT: sel = SEL_INJECT;
            EXIT:   sel = SEL_EXIT;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/fmdll_frame_counter.sv
// Recirculation (N) / sub-frame (M) counter pair with shadowed terminal values.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   clr_i            : force both counters to zero (shadows kept)
//   step_i           : count one delay-line edge
//   m_clr_i          : return sub-frame index to zero (frame completion)
//   shadow_ld_i      : capture n_i/m_i into the shadow registers
//   n_i, m_i         : new terminal values
//   n_cnt_o, m_cnt_o : current counts
//   n_term_o/m_term_o: counter equals its shadow terminal value
module fmdll_frame_counter #(
    parameter int unsigned NW = 4,
    parameter int unsigned MW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          step_i,
    input  logic          m_clr_i,
    input  logic          shadow_ld_i,
    input  logic [NW-1:0] n_i,
    input  logic [MW-1:0] m_i,
    output logic [NW-1:0] n_cnt_o,
    output logic [MW-1:0] m_cnt_o,
    output logic          n_term_o,
    output logic          m_term_o
);

    logic [NW-1:0] n_cnt_q, n_cnt_d, ns_q, ns_d;
    logic [MW-1:0] m_cnt_q, m_cnt_d, ms_q, ms_d;

    assign n_term_o = (n_cnt_q == ns_q);
    assign m_term_o = (m_cnt_q == ms_q);
    assign n_cnt_o  = n_cnt_q;
    assign m_cnt_o  = m_cnt_q;

    always_comb begin
        n_cnt_d = n_cnt_q;
        m_cnt_d = m_cnt_q;
        ns_d    = ns_q;
        ms_d    = ms_q;
        if (clr_i) begin
            n_cnt_d = '0;
            m_cnt_d = '0;
        end else begin
            if (step_i) begin
                if (n_term_o) begin
                    n_cnt_d = '0;
                    // Last sub-frame holds M at Ms; it is cleared on the exit REF.
                    if (!m_term_o) begin
                        m_cnt_d = m_cnt_q + MW'(1);
                    end
                end else begin
                    n_cnt_d = n_cnt_q + NW'(1);
                end
            end
            if (m_clr_i) begin
                m_cnt_d = '0;
            end
        end
        if (shadow_ld_i) begin
            ns_d = n_i;
            ms_d = m_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_cnt_q <= '0;
            m_cnt_q <= '0;
            ns_q    <= '0;
            ms_q    <= '0;
        end else begin
            n_cnt_q <= n_cnt_d;
            m_cnt_q <= m_cnt_d;
            ns_q    <= ns_d;
            ms_q    <= ms_d;
        end
    end

endmodule

// File: rtl/fmdll_sel_sequencer.sv
// FMDLL delay-line input mux select sequencer.
// Counts delay-line edges per sub-frame and sub-frames per frame, steering the
// mux between recirculate, inject-reference and exit, handshaking on REF.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   EN            : enable; low returns to IDLE
//   N, M          : terminal counts (minus one), adopted at start / frame boundary
//   LOAD          : request to adopt N/M at the next frame boundary
//   EDGE, REF     : delay-line edge pulse, reference edge pulse
//   Sel           : 00 recirculate, 10 inject, 01 exit
//   N_counter/M_counter : current counts
//   FRAME         : one-cycle frame completion strobe
//   LOCK_ERR      : sticky handshake error
// Build option: define FMDLL_ERRCHK_EN to build the LOCK_ERR detector;
// otherwise LOCK_ERR is tied low.
module fmdll_sel_sequencer
    import fmdll_pkg::*;
#(
    parameter int unsigned NW = 4,
    parameter int unsigned MW = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [NW-1:0] N,
    input  logic [MW-1:0] M,
    input  logic          LOAD,
    input  logic          EDGE,
    input  logic          REF,
    output logic [1:0]    Sel,
    output logic [NW-1:0] N_counter,
    output logic [MW-1:0] M_counter,
    output logic          FRAME,
    output logic          LOCK_ERR
);

    state_e     state_q, state_d;
    logic       pending_q, pending_d;
    logic       frame_q, frame_d;
    logic [1:0] sel_q;
    logic       cnt_clr, step, m_clr, shadow_ld;
    logic       n_term, m_term;

    fmdll_frame_counter #(
        .NW(NW),
        .MW(MW)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clr_i      (cnt_clr),
        .step_i     (step),
        .m_clr_i    (m_clr),
        .shadow_ld_i(shadow_ld),
        .n_i        (N),
        .m_i        (M),
        .n_cnt_o    (N_counter),
        .m_cnt_o    (M_counter),
        .n_term_o   (n_term),
        .m_term_o   (m_term)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | LOAD;
        frame_d   = 1'b0;
        cnt_clr   = 1'b0;
        step      = 1'b0;
        m_clr     = 1'b0;
        shadow_ld = 1'b0;
        if (state_q != IDLE && !EN) begin
            state_d   = IDLE;
            cnt_clr   = 1'b1;
            pending_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (EN && REF) begin
                        shadow_ld = 1'b1;
                        pending_d = 1'b0;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (EDGE) begin
                        step = 1'b1;
                        if (n_term) begin
                            state_d = m_term ? EXIT : INJECT;
                        end
                    end
                end
                INJECT: begin
                    // EDGE without REF is dropped here.
                    if (REF) begin
                        state_d = RUN;
                    end
                end
                EXIT: begin
                    if (REF) begin
                        state_d = RUN;
                        m_clr   = 1'b1;
                        frame_d = 1'b1;
                        // A LOAD arriving on this very REF still takes effect now.
                        if (pending_q || LOAD) begin
                            shadow_ld = 1'b1;
                            pending_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            sel_q     <= SEL_RECIRC;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            sel_q     <= sel_of(state_d);
        end
    end

    assign Sel   = sel_q;
    assign FRAME = frame_q;

`ifdef FMDLL_ERRCHK_EN
    logic lock_err_q, lock_err_d;
    logic err;

    always_comb begin
        err = 1'b0;
        if (EN) begin
            if ((state_q == INJECT || state_q == EXIT) && EDGE && !REF) begin
                err = 1'b1;
            end
            // REF landing exactly at the sub-frame terminal count means the
            // reference arrived before the expected edge.
            if (state_q == RUN && REF && n_term) begin
                err = 1'b1;
            end
        end
        lock_err_d = lock_err_q | err;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_err_q <= 1'b0;
        end else begin
            lock_err_q <= lock_err_d;
        end
    end

    assign LOCK_ERR = lock_err_q;
`else
    assign LOCK_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_fmdll_sel_sequencer.sv
// Self-checking bench for fmdll_sel_sequencer: directed scenarios against
// literal expectations, then random traffic against a behavioural model.
module tb_fmdll_sel_sequencer;

    localparam int NW = 4;
    localparam int MW = 2;
`ifdef FMDLL_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    localparam int PH_IDLE = 0, PH_RUN = 1, PH_INJ = 2, PH_EXIT = 3;

    logic          CLK = 1'b0;
    logic          RST, EN, LOAD, EDGE, REF;
    logic [NW-1:0] N;
    logic [MW-1:0] M;
    logic [1:0]    Sel;
    logic [NW-1:0] N_counter;
    logic [MW-1:0] M_counter;
    logic          FRAME, LOCK_ERR;

    int checks = 0;
    int errors = 0;
    int cur_n = 0;
    int cur_m = 0;

    // Behavioural model state.
    int md_phase, md_n, md_m, md_ns, md_ms;
    bit md_pend, md_frame, md_err;

    fmdll_sel_sequencer #(
        .NW(NW),
        .MW(MW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .N        (N),
        .M        (M),
        .LOAD     (LOAD),
        .EDGE     (EDGE),
        .REF      (REF),
        .Sel      (Sel),
        .N_counter(N_counter),
        .M_counter(M_counter),
        .FRAME    (FRAME),
        .LOCK_ERR (LOCK_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic int exp_sel(input int ph);
        if (ph == PH_INJ) return 2;
        if (ph == PH_EXIT) return 1;
        return 0;
    endfunction

    task automatic model_step(input bit rst, en, ld, edg, rf, input int nv, mv);
        bit np;
        if (rst) begin
            md_phase = PH_IDLE; md_n = 0; md_m = 0; md_ns = 0; md_ms = 0;
            md_pend = 0; md_frame = 0; md_err = 0;
            return;
        end
        md_frame = 0;
        np = md_pend | ld;
        if (md_phase == PH_IDLE) begin
            if (en && rf) begin
                md_ns = nv; md_ms = mv; np = 0; md_phase = PH_RUN;
            end
        end else if (!en) begin
            md_phase = PH_IDLE; md_n = 0; md_m = 0; np = 0;
        end else if (md_phase == PH_RUN) begin
            if (ERRCHK && rf && md_n == md_ns) md_err = 1;
            if (edg) begin
                if (md_n == md_ns) begin
                    md_n = 0;
                    if (md_m == md_ms) md_phase = PH_EXIT;
                    else begin md_m++; md_phase = PH_INJ; end
                end else md_n++;
            end
        end else begin
            if (rf) begin
                if (md_phase == PH_EXIT) begin
                    md_m = 0; md_frame = 1;
                    if (np) begin md_ns = nv; md_ms = mv; np = 0; end
                end
                md_phase = PH_RUN;
            end else if (edg && ERRCHK) md_err = 1;
        end
        md_pend = np;
    endtask

    task automatic apply(input bit rst, en, ld, edg, rf, input int nv, mv);
        RST = rst; EN = en; LOAD = ld; EDGE = edg; REF = rf;
        N = NW'(nv); M = MW'(mv);
        @(posedge CLK);
        model_step(rst, en, ld, edg, rf, nv, mv);
        #1;
        RST = 0; LOAD = 0; EDGE = 0; REF = 0;
    endtask

    task automatic cyc(input bit ld, edg, rf);
        apply(1'b0, 1'b1, ld, edg, rf, cur_n, cur_m);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur_n, cur_m);
    endtask

    task automatic test_reset();
        cur_n = 3; cur_m = 1;
        do_reset();
        checks += 5;
        if (Sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %0d want 0", Sel); end
        if (N_counter !== 0) begin errors++; $display("FAIL reset_n got %0d want 0", N_counter); end
        if (M_counter !== 0) begin errors++; $display("FAIL reset_m got %0d want 0", M_counter); end
        if (FRAME !== 1'b0) begin errors++; $display("FAIL reset_frame got %0d want 0", FRAME); end
        if (LOCK_ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %0d want 0", LOCK_ERR); end
        cyc(0, 0, 1);
        checks += 3;
        if (Sel !== 2'b00) begin errors++; $display("FAIL start_sel got %0d want 0", Sel); end
        if (N_counter !== 0) begin errors++; $display("FAIL start_n got %0d want 0", N_counter); end
        if (LOCK_ERR !== 1'b0) begin errors++; $display("FAIL start_err got %0d want 0", LOCK_ERR); end
    endtask

    task automatic test_nominal();
        cur_n = 3; cur_m = 1;
        do_reset();
        cyc(0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        checks += 2;
        if (N_counter !== 3) begin errors++; $display("FAIL nom_n3 got %0d want 3", N_counter); end
        if (Sel !== 2'b00) begin errors++; $display("FAIL nom_sel_run got %0d want 0", Sel); end
        cyc(0, 1, 0);
        checks += 3;
        if (Sel !== 2'b10) begin errors++; $display("FAIL nom_inject got %0d want 2", Sel); end
        if (M_counter !== 1) begin errors++; $display("FAIL nom_m1 got %0d want 1", M_counter); end
        if (N_counter !== 0) begin errors++; $display("FAIL nom_nwrap got %0d want 0", N_counter); end
        cyc(0, 0, 1);
        checks++;
        if (Sel !== 2'b00) begin errors++; $display("FAIL nom_rerun got %0d want 0", Sel); end
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        checks++;
        if (Sel !== 2'b01) begin errors++; $display("FAIL nom_exit got %0d want 1", Sel); end
        cyc(0, 0, 1);
        checks += 3;
        if (FRAME !== 1'b1) begin errors++; $display("FAIL nom_frame got %0d want 1", FRAME); end
        if (M_counter !== 0) begin errors++; $display("FAIL nom_mclr got %0d want 0", M_counter); end
        if (Sel !== 2'b00) begin errors++; $display("FAIL nom_frame_sel got %0d want 0", Sel); end
        cyc(0, 0, 0);
        checks++;
        if (FRAME !== 1'b0) begin errors++; $display("FAIL nom_frame_pulse got %0d want 0", FRAME); end
    endtask

    task automatic test_degenerate();
        cur_n = 0; cur_m = 0;
        do_reset();
        cyc(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0);
            checks++;
            if (Sel !== 2'b01) begin errors++; $display("FAIL degen_exit got %0d want 1", Sel); end
            cyc(0, 0, 1);
            checks++;
            if (FRAME !== 1'b1) begin errors++; $display("FAIL degen_frame got %0d want 1", FRAME); end
        end
    endtask

    task automatic test_reload();
        cur_n = 3; cur_m = 1;
        do_reset();
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cur_n = 5;
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        checks++;
        if (Sel !== 2'b10) begin errors++; $display("FAIL reload_old_n got %0d want 2", Sel); end
        cyc(0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        checks++;
        if (Sel !== 2'b01) begin errors++; $display("FAIL reload_exit got %0d want 1", Sel); end
        cyc(0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0);
        checks += 2;
        if (N_counter !== 5) begin errors++; $display("FAIL reload_n5 got %0d want 5", N_counter); end
        if (Sel !== 2'b00) begin errors++; $display("FAIL reload_still_run got %0d want 0", Sel); end
        cyc(0, 1, 0);
        checks++;
        if (Sel !== 2'b10) begin errors++; $display("FAIL reload_new_n got %0d want 2", Sel); end
    endtask

    task automatic test_error();
        cur_n = 1; cur_m = 1;
        do_reset();
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        checks += 3;
        if (LOCK_ERR !== ERRCHK) begin errors++; $display("FAIL err_set got %0d want %0d", LOCK_ERR, ERRCHK); end
        if (Sel !== 2'b10) begin errors++; $display("FAIL err_sel got %0d want 2", Sel); end
        if (N_counter !== 0) begin errors++; $display("FAIL err_nocount got %0d want 0", N_counter); end
        apply(0, 0, 0, 0, 0, cur_n, cur_m);
        cyc(0, 0, 1);
        checks++;
        if (LOCK_ERR !== ERRCHK) begin errors++; $display("FAIL err_sticky got %0d want %0d", LOCK_ERR, ERRCHK); end
        do_reset();
        checks++;
        if (LOCK_ERR !== 1'b0) begin errors++; $display("FAIL err_clear got %0d want 0", LOCK_ERR); end
    endtask

    task automatic test_abort();
        cur_n = 1; cur_m = 1;
        do_reset();
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        checks++;
        if (M_counter !== 1) begin errors++; $display("FAIL abort_pre_m got %0d want 1", M_counter); end
        apply(0, 0, 0, 0, 0, cur_n, cur_m);
        checks += 3;
        if (Sel !== 2'b00) begin errors++; $display("FAIL abort_sel got %0d want 0", Sel); end
        if (N_counter !== 0) begin errors++; $display("FAIL abort_n got %0d want 0", N_counter); end
        if (M_counter !== 0) begin errors++; $display("FAIL abort_m got %0d want 0", M_counter); end
        cur_n = 0; cur_m = 0;
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 1);
        checks += 4;
        if (FRAME !== 1'b1) begin errors++; $display("FAIL both_frame got %0d want 1", FRAME); end
        if (N_counter !== 0) begin errors++; $display("FAIL both_n got %0d want 0", N_counter); end
        if (Sel !== 2'b00) begin errors++; $display("FAIL both_sel got %0d want 0", Sel); end
        if (LOCK_ERR !== 1'b0) begin errors++; $display("FAIL both_noerr got %0d want 0", LOCK_ERR); end
    endtask

    task automatic test_random();
        bit rst, en, ld, edg, rf;
        int nv, mv;
        do_reset();
        nv = 2; mv = 1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 49) != 0);
            ld  = ($urandom_range(0, 19) == 0);
            edg = ($urandom_range(0, 9) < 4);
            rf  = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 15) == 0) begin
                nv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
                mv = $urandom_range(0, 3);
            end
            apply(rst, en, ld, edg, rf, nv, mv);
            checks += 5;
            if (Sel !== 2'(exp_sel(md_phase))) begin
                errors++; $display("FAIL rnd_sel cyc %0d got %0d want %0d", i, Sel, exp_sel(md_phase));
            end
            if (N_counter !== NW'(md_n)) begin
                errors++; $display("FAIL rnd_n cyc %0d got %0d want %0d", i, N_counter, md_n);
            end
            if (M_counter !== MW'(md_m)) begin
                errors++; $display("FAIL rnd_m cyc %0d got %0d want %0d", i, M_counter, md_m);
            end
            if (FRAME !== md_frame) begin
                errors++; $display("FAIL rnd_frame cyc %0d got %0d want %0d", i, FRAME, md_frame);
            end
            if (LOCK_ERR !== md_err) begin
                errors++; $display("FAIL rnd_err cyc %0d got %0d want %0d", i, LOCK_ERR, md_err);
            end
        end
    endtask

    initial begin
        RST = 1; EN = 0; LOAD = 0; EDGE = 0; REF = 0; N = '0; M = '0;
        @(negedge CLK);
        test_reset();
        test_nominal();
        test_degenerate();
        test_reload();
        test_error();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
